// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues in-order word reads to imem and buffers responses for decode.
// Define FETCH_MISALIGN_CHK_EN to trap misaligned redirects into a sticky HALT with fault_o set.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        fault_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW+1:0] DEPTH = (AW+2)'(FIFO_DEPTH);
    localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};

`ifdef FETCH_MISALIGN_CHK_EN
    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;
`else
    typedef enum logic [1:0] {BOOT, RUN} state_t;
`endif

    state_t        state;
    logic [31:0]   pc;
    logic [31:0]   fifo_dat [FIFO_DEPTH];
    logic [31:0]   fifo_pc  [FIFO_DEPTH];
    logic [31:0]   infl_pc  [FIFO_DEPTH];
    logic [AW:0]   fifo_wr;
    logic [AW:0]   fifo_rd;
    logic [AW:0]   infl_wr;
    logic [AW:0]   infl_rd;
    logic [AW:0]   kill_cnt;
    logic [AW:0]   fifo_cnt;
    logic [AW:0]   out_cnt;
    logic [AW+1:0] occupancy;
    logic          gnt_acc;
    logic          rsp;
    logic          push;
    logic          pop;
    logic          redir;
    logic          halted;
    logic [31:0]   target;

    assign fifo_cnt  = fifo_wr - fifo_rd;
    assign out_cnt   = infl_wr - infl_rd;
    assign occupancy = {1'b0, out_cnt} + {1'b0, fifo_cnt};

    // In-flight requests (including ones already marked for killing) reserve FIFO space.
    assign imem_req_o  = (state == RUN) && (occupancy < DEPTH);
    assign imem_addr_o = pc;
    assign gnt_acc     = imem_req_o && imem_gnt_i;
    // A response with nothing outstanding is stale (e.g. from before reset) and is ignored.
    assign rsp         = imem_rvalid_i && (out_cnt != '0);

    assign instr_valid_o = (fifo_cnt != '0);
    assign pop           = instr_valid_o && instr_ready_i;
    assign instr_o       = instr_valid_o ? fifo_dat[fifo_rd[AW-1:0]] : '0;
    assign instr_pc_o    = instr_valid_o ? fifo_pc[fifo_rd[AW-1:0]]  : '0;

    assign redir  = redirect_i && !halted;
    assign target = {redirect_pc_i[31:2], 2'b00};
    assign push   = rsp && (kill_cnt == '0) && !redir && !halted;

`ifdef FETCH_MISALIGN_CHK_EN
    logic fault;
    logic misalign;
    assign halted   = (state == HALT);
    assign misalign = redir && (redirect_pc_i[1:0] != 2'b00);
    assign fault_o  = fault;
`else
    logic unused_pc_lsb;
    assign unused_pc_lsb = ^redirect_pc_i[1:0];
    assign halted        = 1'b0;
    assign fault_o       = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state    <= BOOT;
            pc       <= RESET_PC;
            fifo_wr  <= '0;
            fifo_rd  <= '0;
            infl_wr  <= '0;
            infl_rd  <= '0;
            kill_cnt <= '0;
`ifdef FETCH_MISALIGN_CHK_EN
            fault    <= 1'b0;
`endif
        end else begin
            if (state == BOOT) begin
                state <= RUN;
            end

            if (gnt_acc) begin
                infl_pc[infl_wr[AW-1:0]] <= pc;
                infl_wr                  <= infl_wr + CNT_ONE;
            end
            if (rsp) begin
                infl_rd <= infl_rd + CNT_ONE;
            end

            if (push) begin
                fifo_dat[fifo_wr[AW-1:0]] <= imem_rdata_i;
                fifo_pc[fifo_wr[AW-1:0]]  <= infl_pc[infl_rd[AW-1:0]];
                fifo_wr                   <= fifo_wr + CNT_ONE;
            end
            if (pop) begin
                fifo_rd <= fifo_rd + CNT_ONE;
            end
            // A same-cycle pop has already been seen by decode; the clear only drops the rest.
            if (redir || halted) begin
                fifo_wr <= '0;
                fifo_rd <= '0;
            end

            // Every request still outstanding after this cycle belongs to the old path.
            if (redir) begin
                kill_cnt <= out_cnt + {{AW{1'b0}}, gnt_acc} - {{AW{1'b0}}, rsp};
                pc       <= target;
            end else begin
                if (rsp && (kill_cnt != '0)) begin
                    kill_cnt <= kill_cnt - CNT_ONE;
                end
                if (gnt_acc) begin
                    pc <= pc + 32'd4;
                end
            end

`ifdef FETCH_MISALIGN_CHK_EN
            if (misalign) begin
                state <= HALT;
                fault <= 1'b1;
            end
`endif
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: in-order memory model plus a PC-stream reference for decode output.
module tb_instr_fetch_unit;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b0;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        fault_o;

    logic        hi_req;
    logic [31:0] hi_addr;
    logic        hi_rvalid = 1'b0;
    logic        hi_valid;
    logic [31:0] hi_instr;
    logic [31:0] hi_pc;
    logic        hi_fault;

    instr_fetch_unit dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
        .instr_o(instr_o), .instr_pc_o(instr_pc_o), .fault_o(fault_o)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut_hi (
        .clk_i(clk_i), .rst_i(rst_i),
        .imem_req_o(hi_req), .imem_addr_o(hi_addr), .imem_gnt_i(1'b1),
        .imem_rvalid_i(hi_rvalid), .imem_rdata_i(32'h0),
        .redirect_i(1'b0), .redirect_pc_i(32'h0),
        .instr_valid_o(hi_valid), .instr_ready_i(1'b1),
        .instr_o(hi_instr), .instr_pc_o(hi_pc), .fault_o(hi_fault)
    );

    always #5 clk_i = ~clk_i;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] memq[$];
    logic [31:0] hi_addrs[$];
    int          hi_cnt = 0;
    logic        rst_nx = 1'b0;
    logic        ready_nx = 1'b0;
    logic        redir_nx = 1'b0;
    logic [31:0] redir_pc_nx = '0;
    logic        gnt_en = 1'b1;
    logic        gnt_rand = 1'b0;
    logic        rv_rand = 1'b0;
    logic        rv_hold = 1'b0;
    logic        auto_redir = 1'b0;
    logic        fired = 1'b0;
    logic [31:0] exp_pc = '0;
    logic        d;
    logic [31:0] dp;
    logic [31:0] di;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
    endfunction

    // One clock: drive inputs at negedge, let combinational outputs settle, report any delivery.
    task automatic cycle(output logic dlv, output logic [31:0] dpc, output logic [31:0] dins);
        @(negedge clk_i);
        rst_i         = rst_nx;
        instr_ready_i = ready_nx;
        redirect_i    = redir_nx;
        redirect_pc_i = redir_pc_nx;
        redir_nx      = 1'b0;
        imem_gnt_i    = gnt_rand ? ($urandom_range(0, 1) == 1) : gnt_en;
        if (rst_i && memq.size() > 0 && !rv_hold && (!rv_rand || $urandom_range(0, 1) == 1)) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = memf(memq.pop_front());
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = $urandom();
        end
        if (auto_redir && instr_valid_o && imem_rvalid_i && instr_ready_i) begin
            redirect_i = 1'b1;
            auto_redir = 1'b0;
            fired      = 1'b1;
        end
        hi_rvalid = rst_i && (hi_cnt > 0);
        if (hi_rvalid) hi_cnt--;
        #1;
        if (!rst_i) begin
            memq.delete();
            hi_addrs.delete();
            hi_cnt = 0;
        end else begin
            if (imem_req_o && imem_gnt_i) memq.push_back(imem_addr_o);
            if (hi_req) begin
                hi_cnt++;
                hi_addrs.push_back(hi_addr);
            end
        end
        dlv  = instr_valid_o && instr_ready_i;
        dpc  = instr_pc_o;
        dins = instr_o;
    endtask

    task automatic test_reset();
        rst_nx = 1'b0; auto_redir = 1'b0; gnt_en = 1'b1; gnt_rand = 1'b0; rv_rand = 1'b0; rv_hold = 1'b0;
        repeat (2) cycle(d, dp, di);
        checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem_req_o); end
        checks++; if (imem_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 00000000", imem_addr_o); end
        checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", instr_valid_o); end
        checks++; if (instr_o !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 0", instr_o); end
        checks++; if (instr_pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", instr_pc_o); end
        checks++; if (fault_o !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b expected 0", fault_o); end
        checks++; if (hi_addr !== 32'hFFFF_FFF8) begin errors++; $display("FAIL reset_hi_addr: got %h expected fffffff8", hi_addr); end
        rst_nx = 1'b1;
        exp_pc = 32'h0;
    endtask

    task automatic test_stream();
        int n = 0;
        ready_nx = 1'b1;
        repeat (40) begin
            cycle(d, dp, di);
            if (d) begin
                checks++;
                if (dp !== exp_pc || di !== memf(exp_pc)) begin
                    errors++; $display("FAIL stream: got %h/%h expected %h/%h", dp, di, exp_pc, memf(exp_pc));
                end
                exp_pc += 4; n++;
            end
        end
        checks++; if (n < 15) begin errors++; $display("FAIL stream_count: got %0d expected >=15", n); end
    endtask

    task automatic test_stall();
        logic [31:0] held;
        int n = 0;
        ready_nx = 1'b0;
        repeat (10) cycle(d, dp, di);
        checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL stall_req: got %b expected 0", imem_req_o); end
        checks++; if (instr_valid_o !== 1'b1) begin errors++; $display("FAIL stall_valid: got %b expected 1", instr_valid_o); end
        checks++; if (instr_pc_o !== exp_pc) begin errors++; $display("FAIL stall_head_pc: got %h expected %h", instr_pc_o, exp_pc); end
        held = instr_o;
        checks++; if (held !== memf(exp_pc)) begin errors++; $display("FAIL stall_head_instr: got %h expected %h", held, memf(exp_pc)); end
        repeat (3) begin
            cycle(d, dp, di);
            checks++; if (instr_o !== held) begin errors++; $display("FAIL stall_stable: got %h expected %h", instr_o, held); end
        end
        gnt_en = 1'b0; ready_nx = 1'b1;
        repeat (6) begin
            cycle(d, dp, di);
            if (d) begin
                checks++;
                if (dp !== exp_pc || di !== memf(exp_pc)) begin
                    errors++; $display("FAIL stall_drain: got %h/%h expected %h/%h", dp, di, exp_pc, memf(exp_pc));
                end
                exp_pc += 4; n++;
            end
        end
        checks++; if (n != 2) begin errors++; $display("FAIL stall_buffered: got %0d expected 2", n); end
        gnt_en = 1'b1;
    endtask

    task automatic test_redirect_inflight();
        int n = 0;
        rv_hold = 1'b1; ready_nx = 1'b1;
        repeat (4) cycle(d, dp, di);
        checks++; if (memq.size() != 2) begin errors++; $display("FAIL inflight_count: got %0d expected 2", memq.size()); end
        checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL inflight_req: got %b expected 0", imem_req_o); end
        redir_nx = 1'b1; redir_pc_nx = 32'h100;
        cycle(d, dp, di);
        checks++; if (d !== 1'b0) begin errors++; $display("FAIL redir_no_pop: got %b expected 0", d); end
        exp_pc = 32'h100; rv_hold = 1'b0;
        cycle(d, dp, di);
        checks++; if (imem_addr_o !== 32'h100) begin errors++; $display("FAIL redir_addr: got %h expected 00000100", imem_addr_o); end
        repeat (15) begin
            cycle(d, dp, di);
            if (d) begin
                checks++;
                if (dp !== exp_pc || di !== memf(exp_pc)) begin
                    errors++; $display("FAIL redir_stream: got %h/%h expected %h/%h", dp, di, exp_pc, memf(exp_pc));
                end
                exp_pc += 4; n++;
            end
        end
        checks++; if (n < 3) begin errors++; $display("FAIL redir_resume: got %0d expected >=3", n); end
    endtask

    task automatic test_redirect_pop();
        int  n = 0;
        int  k = 0;
        logic fd = 1'b0;
        ready_nx = 1'b1; redir_pc_nx = 32'h200; fired = 1'b0; auto_redir = 1'b1;
        while (!fired && k < 30) begin
            cycle(d, dp, di);
            k++;
            if (d) begin
                checks++;
                if (dp !== exp_pc || di !== memf(exp_pc)) begin
                    errors++; $display("FAIL pop_pre: got %h/%h expected %h/%h", dp, di, exp_pc, memf(exp_pc));
                end
                exp_pc += 4;
            end
            fd = d;
        end
        auto_redir = 1'b0;
        checks++; if (fired !== 1'b1) begin errors++; $display("FAIL pop_redir_trigger: got %b expected 1", fired); end
        checks++; if (fd !== 1'b1) begin errors++; $display("FAIL pop_redir_delivered: got %b expected 1", fd); end
        exp_pc = 32'h200;
        repeat (15) begin
            cycle(d, dp, di);
            if (d) begin
                checks++;
                if (dp !== exp_pc || di !== memf(exp_pc)) begin
                    errors++; $display("FAIL pop_post: got %h/%h expected %h/%h", dp, di, exp_pc, memf(exp_pc));
                end
                exp_pc += 4; n++;
            end
        end
        checks++; if (n < 3) begin errors++; $display("FAIL pop_resume: got %0d expected >=3", n); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_w [3];
        exp_w[0] = 32'hFFFF_FFF8; exp_w[1] = 32'hFFFF_FFFC; exp_w[2] = 32'h0000_0000;
        checks++;
        if (hi_addrs.size() < 3) begin
            errors++; $display("FAIL wrap_count: got %0d expected >=3", hi_addrs.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (hi_addrs[i] !== exp_w[i]) begin
                    errors++; $display("FAIL wrap_addr%0d: got %h expected %h", i, hi_addrs[i], exp_w[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        int          n = 0;
        logic        r;
        logic [31:0] tgt;
        gnt_rand = 1'b1; rv_rand = 1'b1;
        repeat (400) begin
            ready_nx = ($urandom_range(0, 1) == 1);
            r   = ($urandom_range(0, 15) == 0);
            tgt = $urandom() & 32'hFFFF_FFFC;
            if (r) begin redir_nx = 1'b1; redir_pc_nx = tgt; end
            cycle(d, dp, di);
            if (d) begin
                checks++;
                if (dp !== exp_pc || di !== memf(exp_pc)) begin
                    errors++; $display("FAIL random: got %h/%h expected %h/%h", dp, di, exp_pc, memf(exp_pc));
                end
                exp_pc += 4; n++;
            end
            if (r) exp_pc = tgt;
        end
        checks++; if (n < 20) begin errors++; $display("FAIL random_count: got %0d expected >=20", n); end
        gnt_rand = 1'b0; rv_rand = 1'b0; ready_nx = 1'b1;
    endtask

    task automatic test_misalign();
        int n = 0;
        ready_nx = 1'b1;
        redir_nx = 1'b1; redir_pc_nx = 32'h102;
        cycle(d, dp, di);
        if (d) begin
            checks++;
            if (dp !== exp_pc) begin errors++; $display("FAIL mis_pop: got %h expected %h", dp, exp_pc); end
        end
`ifdef FETCH_MISALIGN_CHK_EN
        repeat (8) begin
            cycle(d, dp, di);
            checks++; if (fault_o !== 1'b1) begin errors++; $display("FAIL mis_fault: got %b expected 1", fault_o); end
            checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL mis_req: got %b expected 0", imem_req_o); end
            checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL mis_valid: got %b expected 0", instr_valid_o); end
        end
`else
        exp_pc = 32'h100;
        repeat (15) begin
            cycle(d, dp, di);
            if (d) begin
                checks++;
                if (dp !== exp_pc || di !== memf(exp_pc)) begin
                    errors++; $display("FAIL mis_stream: got %h/%h expected %h/%h", dp, di, exp_pc, memf(exp_pc));
                end
                exp_pc += 4; n++;
            end
        end
        checks++; if (n < 3) begin errors++; $display("FAIL mis_resume: got %0d expected >=3", n); end
        checks++; if (fault_o !== 1'b0) begin errors++; $display("FAIL mis_fault: got %b expected 0", fault_o); end
`endif
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_inflight();
        test_redirect_pop();
        test_wrap();
        test_random();
        test_misalign();
        test_reset();
        test_stream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
